// File: rtl/grid_step_ctrl.sv
// grid_step_ctrl
//
// Sequential move controller for a 16x16 grid. A move command (axis,
// direction, 2-bit step) is accepted over a valid/ready handshake, the
// selected coordinate and the step are run through a 4-bit complement
// add/subtract stage, and the carry/borrow out of that stage decides whether
// the move stays on the grid. In-range moves are committed. Out-of-range
// moves are blocked, leaving the position unchanged.
//
// Each command takes three cycles: IDLE (accept), CALC (add), UPDATE (commit).
//
// Parameters:
//   START_X, START_Y : position loaded by reset (0..15)
//   CNT_W            : width of the saturating statistics counters (>= 2)
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-high reset
//   cmd_valid  in   command present
//   cmd_ready  out  controller idle and able to accept (decoded from state)
//   cmd_dir    in   00 +x, 01 -x, 10 +y, 11 -y
//   cmd_step   in   step magnitude 0..3
//   pos_x      out  current x coordinate
//   pos_y      out  current y coordinate
//   done_valid out  one-cycle pulse when a command completes
//   blocked    out  with done_valid: 1 = move rejected, position unchanged
//   move_cnt   out  completed commands, saturating
//   block_cnt  out  blocked commands, saturating
//
// Build option:
//   GRID_WRAP_EN : when defined, out-of-range moves wrap modulo 16 instead of
//                  being blocked. blocked stays 0 and block_cnt stays 0.

module grid_step_ctrl #(
  parameter int START_X = 0,
  parameter int START_Y = 0,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_dir,
  input  logic [1:0]       cmd_step,
  output logic [3:0]       pos_x,
  output logic [3:0]       pos_y,
  output logic             done_valid,
  output logic             blocked,
  output logic [CNT_W-1:0] move_cnt,
  output logic [CNT_W-1:0] block_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    UPDATE = 2'd2
  } state_e;

  localparam logic [3:0]       START_X_L = START_X[3:0];
  localparam logic [3:0]       START_Y_L = START_Y[3:0];
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [1:0]       dir_q;
  logic [1:0]       step_q;
  logic [3:0]       sum_q;
  logic             last_q;
  logic [3:0]       pos_x_q, pos_y_q;
  logic             done_q, blocked_q;
  logic [CNT_W-1:0] move_cnt_q, block_cnt_q;

  // Adder stage operands.
  logic [3:0] add_pos;
  logic       add_op;
  logic [3:0] add_b;
  logic [4:0] add_res;
  logic       commit;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_d = CALC;
        end
      end
      CALC:    state_d = UPDATE;
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Complement add/subtract stage.
  // Subtraction is pos + ~step + 1. The carry out of bit 3 is therefore
  // "no borrow" when subtracting and "overflow" when adding.
  // ---------------------------------------------------------------------------
  assign add_pos = dir_q[1] ? pos_y_q : pos_x_q;
  assign add_op  = dir_q[0];
  assign add_b   = add_op ? ~{2'b00, step_q} : {2'b00, step_q};
  assign add_res = {1'b0, add_pos} + {1'b0, add_b} + {4'b0000, add_op};

`ifdef GRID_WRAP_EN
  // The 4-bit sum is already the coordinate modulo 16.
  assign commit = 1'b1;
`else
  // In range: an add must not carry out, and a subtract must carry out
  // (no borrow).
  assign commit = add_op ? last_q : ~last_q;
`endif

  // ---------------------------------------------------------------------------
  // Datapath, position and statistics
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dir_q       <= 2'b00;
      step_q      <= 2'b00;
      sum_q       <= 4'h0;
      last_q      <= 1'b0;
      pos_x_q     <= START_X_L;
      pos_y_q     <= START_Y_L;
      done_q      <= 1'b0;
      blocked_q   <= 1'b0;
      move_cnt_q  <= '0;
      block_cnt_q <= '0;
    end else begin
      // done/blocked are single-cycle, so both default low.
      done_q    <= 1'b0;
      blocked_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            dir_q  <= cmd_dir;
            step_q <= cmd_step;
          end
        end
        CALC: begin
          sum_q  <= add_res[3:0];
          last_q <= add_res[4];
        end
        UPDATE: begin
          done_q    <= 1'b1;
          blocked_q <= ~commit;
          if (commit) begin
            if (dir_q[1]) begin
              pos_y_q <= sum_q;
            end else begin
              pos_x_q <= sum_q;
            end
          end
          if (move_cnt_q != CNT_MAX) begin
            move_cnt_q <= move_cnt_q + CNT_ONE;
          end
          if (!commit && (block_cnt_q != CNT_MAX)) begin
            block_cnt_q <= block_cnt_q + CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign pos_x      = pos_x_q;
  assign pos_y      = pos_y_q;
  assign done_valid = done_q;
  assign blocked    = blocked_q;
  assign move_cnt   = move_cnt_q;
  assign block_cnt  = block_cnt_q;

endmodule

// File: tb/tb_grid_step_ctrl.sv
// Testbench for grid_step_ctrl.
// Two instances share the same stimulus: one with 8-bit counters and one
// with 2-bit counters (to reach saturation). A reference model computes
// each command's outcome when it is accepted and pushes it to a queue. The
// entry is popped and compared when done_valid appears.

module tb_grid_step_ctrl;

  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic [1:0] cmd_dir;
  logic [1:0] cmd_step;

  logic       cmd_ready, done_valid, blocked;
  logic [3:0] pos_x, pos_y;
  logic [7:0] move_cnt, block_cnt;

  logic       s_cmd_ready, s_done_valid, s_blocked;
  logic [3:0] s_pos_x, s_pos_y;
  logic [1:0] s_move_cnt, s_block_cnt;

  grid_step_ctrl #(.START_X(0), .START_Y(0), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_step(cmd_step), .pos_x(pos_x), .pos_y(pos_y),
    .done_valid(done_valid), .blocked(blocked),
    .move_cnt(move_cnt), .block_cnt(block_cnt)
  );

  grid_step_ctrl #(.START_X(0), .START_Y(0), .CNT_W(2)) dut_small (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(s_cmd_ready),
    .cmd_dir(cmd_dir), .cmd_step(cmd_step), .pos_x(s_pos_x), .pos_y(s_pos_y),
    .done_valid(s_done_valid), .blocked(s_blocked),
    .move_cnt(s_move_cnt), .block_cnt(s_block_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int blk;
    int mc;
    int bc;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   mx = 0, my = 0, mmc = 0, mbc = 0;

  function automatic int sat(input int v, input int w);
    int mx_v;
    mx_v = (1 << w) - 1;
    return (v > mx_v) ? mx_v : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: predict the outcome of a command when it is accepted.
  task automatic model_push(input logic [1:0] d, input logic [1:0] s);
    int   coord, nv, inr;
    exp_t e;
    coord = d[1] ? my : mx;
    if (d[0]) begin
      nv  = coord - int'(s);
      inr = (int'(s) <= coord) ? 1 : 0;
    end else begin
      nv  = coord + int'(s);
      inr = (nv <= 15) ? 1 : 0;
    end
`ifdef GRID_WRAP_EN
    inr = 1;
`endif
    if (inr == 1) begin
      if (d[1]) my = nv & 15;
      else      mx = nv & 15;
    end else begin
      mbc++;
    end
    mmc++;
    e.x = mx; e.y = my; e.blk = (inr == 1) ? 0 : 1; e.mc = mmc; e.bc = mbc;
    q.push_back(e);
  endtask

  // Called at a negedge. Keeps cmd_valid high afterwards so that consecutive
  // calls exercise a continuously asserted request.
  task automatic accept(input logic [1:0] d, input logic [1:0] s);
    int waitc;
    waitc = 0;
    while (cmd_ready !== 1'b1 && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    chk("ready_wait", 32'(waitc < 20), 32'd1);
    cmd_valid = 1'b1;
    cmd_dir   = d;
    cmd_step  = s;
    @(posedge clk);
    model_push(d, s);
    @(negedge clk);
  endtask

  // Called at the negedge after acceptance (CALC).
  task automatic wait_done();
    exp_t e;
    chk("calc_ready", 32'(cmd_ready), 32'd0);
    chk("calc_done", 32'(done_valid), 32'd0);
    chk("calc_blocked", 32'(blocked), 32'd0);
    @(negedge clk);
    chk("update_ready", 32'(cmd_ready), 32'd0);
    chk("update_done", 32'(done_valid), 32'd0);
    @(negedge clk);
    chk("done_valid", 32'(done_valid), 32'd1);
    chk("done_ready", 32'(cmd_ready), 32'd1);
    chk("sb_nonempty", 32'(q.size() > 0), 32'd1);
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("pos_x", 32'(pos_x), 32'(e.x));
      chk("pos_y", 32'(pos_y), 32'(e.y));
      chk("blocked", 32'(blocked), 32'(e.blk));
      chk("move_cnt", 32'(move_cnt), 32'(sat(e.mc, 8)));
      chk("block_cnt", 32'(block_cnt), 32'(sat(e.bc, 8)));
      chk("s_pos_x", 32'(s_pos_x), 32'(e.x));
      chk("s_pos_y", 32'(s_pos_y), 32'(e.y));
      chk("s_move_cnt", 32'(s_move_cnt), 32'(sat(e.mc, 2)));
      chk("s_block_cnt", 32'(s_block_cnt), 32'(sat(e.bc, 2)));
    end
    $display("cmd done: pos=(%0d,%0d) blocked=%0b move_cnt=%0d block_cnt=%0d",
             pos_x, pos_y, blocked, move_cnt, block_cnt);
  endtask

  task automatic issue(input logic [1:0] d, input logic [1:0] s);
    accept(d, s);
    wait_done();
  endtask

  // Walk the model (and the DUT) to a target with in-range moves.
  task automatic goto(input int tx, input int ty);
    int guard;
    guard = 0;
    while ((mx != tx || my != ty) && guard < 20) begin
      if (mx < tx)      issue(2'b00, (tx - mx > 3) ? 2'd3 : 2'(tx - mx));
      else if (mx > tx) issue(2'b01, (mx - tx > 3) ? 2'd3 : 2'(mx - tx));
      else if (my < ty) issue(2'b10, (ty - my > 3) ? 2'd3 : 2'(ty - my));
      else              issue(2'b11, (my - ty > 3) ? 2'd3 : 2'(my - ty));
      guard++;
    end
    chk("goto_reached", 32'(guard < 20), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_dir   = 2'b00;
    cmd_step  = 2'b00;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_pos_x", 32'(pos_x), 32'd0);
    chk("rst_pos_y", 32'(pos_y), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_done", 32'(done_valid), 32'd0);
    chk("rst_blocked", 32'(blocked), 32'd0);
    chk("rst_move_cnt", 32'(move_cnt), 32'd0);
    chk("rst_block_cnt", 32'(block_cnt), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Back-to-back moves with cmd_valid held: +x3 then +y2
    issue(2'b00, 2'd3);
    issue(2'b10, 2'd2);

    // Reset during UPDATE aborts the command asynchronously
    accept(2'b00, 2'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    reset     = 1'b1;
    #1;
    chk("arst_pos_x", 32'(pos_x), 32'd0);
    chk("arst_pos_y", 32'(pos_y), 32'd0);
    chk("arst_ready", 32'(cmd_ready), 32'd1);
    chk("arst_done", 32'(done_valid), 32'd0);
    chk("arst_move_cnt", 32'(move_cnt), 32'd0);
    chk("arst_s_move_cnt", 32'(s_move_cnt), 32'd0);
    mx = 0; my = 0; mmc = 0; mbc = 0;
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("arst_no_done", 32'(done_valid), 32'd0);
    end
    chk("arst_cnt_hold", 32'(move_cnt), 32'd0);

    // Overflow on +x from (14,5)
    goto(14, 5);
    issue(2'b00, 2'd3);

    // Borrow on -x from (1,0)
    goto(1, 0);
    issue(2'b01, 2'd2);

    // -x step 0 from (0,0) is in range
    goto(0, 0);
    issue(2'b01, 2'd0);

    // Five out-of-range commands drive the 2-bit counters into saturation
    for (int i = 0; i < 5; i++) begin
      issue(2'b11, 2'd3);
    end

    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("final_sb_empty", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
